// File: rtl/typing_pkg.sv
// Shared constants and FSM encoding for the typing session controller and its ROM port arbiter.
package typing_pkg;

  localparam logic [1:0] SEL_TITLE = 2'd0;
  localparam logic [1:0] SEL_MAIN  = 2'd1;
  localparam logic [1:0] SEL_INIT  = 2'd2;
  localparam logic [1:0] SEL_FINAL = 2'd3;

  localparam logic [1:0] PHASE_TITLE    = 2'd0;
  localparam logic [1:0] PHASE_TYPING   = 2'd1;
  localparam logic [1:0] PHASE_FINISHED = 2'd3;

  localparam logic [6:0] ASCII_BS = 7'h08;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rom_port_arb.sv
// Shares the single prompt ROM read port between the VGA renderer and the keystroke compare engine.
// VGA wins by default; a pending compare is forced through after STARVE_MAX lost cycles.
module rom_port_arb
  import typing_pkg::*;
#(
  parameter int IDX_W      = 12,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmp_req,
  input  logic [IDX_W-1:0] cmp_idx,
  output logic             cmp_grant,
  input  logic             vga_req,
  input  logic [1:0]       vga_sel,
  input  logic [IDX_W-1:0] vga_idx,
  output logic             vga_ack,
  output logic [6:0]       vga_char,
  output logic [1:0]       rom_sel,
  output logic [IDX_W-1:0] rom_idx,
  input  logic [6:0]       rom_char
);

  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;
  logic                vga_grant;

  always_comb begin
    cmp_grant = cmp_req && (!vga_req || (starve_cnt == STARVE_LIM));
    vga_grant = vga_req && !cmp_grant;
  end

  // The ROM address is combinational so the ROM answers within the granted cycle.
  always_comb begin
    rom_sel = vga_sel;
    rom_idx = vga_idx;
    if (!rst_n) begin
      rom_sel = '0;
      rom_idx = '0;
    end else if (cmp_grant) begin
      rom_sel = SEL_MAIN;
      rom_idx = cmp_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      vga_ack    <= 1'b0;
      vga_char   <= '0;
    end else begin
      vga_ack <= vga_grant;
      if (vga_grant) begin
        vga_char <= rom_char;
      end
      if (!cmp_req || cmp_grant) begin
        starve_cnt <= '0;
      end else begin
        starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end

endmodule

// File: rtl/typing_session_ctrl.sv
// Typing session sequencer: title -> typing -> finished, keystroke compare and error count.
// Optional build macro TYPING_BACKSPACE_EN makes 0x08 in WAIT step the cursor back instead of comparing.
module typing_session_ctrl
  import typing_pkg::*;
#(
  parameter int MAIN_LEN   = 192,
  parameter int IDX_W      = 12,
  parameter int ERR_W      = 8,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [6:0]       key_code,
  output logic             key_ready,
  input  logic             vga_req,
  input  logic [1:0]       vga_sel,
  input  logic [IDX_W-1:0] vga_idx,
  output logic             vga_ack,
  output logic [6:0]       vga_char,
  output logic [1:0]       rom_sel,
  output logic [IDX_W-1:0] rom_idx,
  input  logic [6:0]       rom_char,
  output logic [1:0]       phase,
  output logic [IDX_W-1:0] cursor,
  output logic [ERR_W-1:0] err_cnt,
  output logic             done
);

  // state   | meaning
  // ST_IDLE | title screen, any key starts a session
  // ST_WAIT | typing, waiting for the next keystroke
  // ST_CMP  | comparing key_q with the main prompt at cursor
  // ST_DONE | prompt completed, any key returns to title

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAIN_LEN - 1);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(MAIN_LEN);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t     state;
  logic [6:0] key_q;
  logic       key_acc;
  logic       cmp_grant;
  logic       is_bs;

  assign key_ready = (state != ST_CMP);
  assign key_acc   = key_valid && key_ready;

`ifdef TYPING_BACKSPACE_EN
  assign is_bs = (key_code == ASCII_BS);
`else
  assign is_bs = 1'b0;
`endif

  rom_port_arb #(
    .IDX_W      (IDX_W),
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmp_req   (state == ST_CMP),
    .cmp_idx   (cursor),
    .cmp_grant (cmp_grant),
    .vga_req   (vga_req),
    .vga_sel   (vga_sel),
    .vga_idx   (vga_idx),
    .vga_ack   (vga_ack),
    .vga_char  (vga_char),
    .rom_sel   (rom_sel),
    .rom_idx   (rom_idx),
    .rom_char  (rom_char)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cursor  <= '0;
      err_cnt <= '0;
      key_q   <= '0;
      phase   <= PHASE_TITLE;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_acc) begin
            state   <= ST_WAIT;
            cursor  <= '0;
            err_cnt <= '0;
            phase   <= PHASE_TYPING;
          end
        end
        ST_WAIT: begin
          if (key_acc) begin
            if (is_bs) begin
              if (cursor != '0) begin
                cursor <= cursor - IDX_W'(1);
              end
            end else begin
              key_q <= key_code;
              state <= ST_CMP;
            end
          end
        end
        ST_CMP: begin
          if (cmp_grant) begin
            if (rom_char == key_q) begin
              if (cursor == LAST_IDX) begin
                cursor <= END_IDX;
                state  <= ST_DONE;
                phase  <= PHASE_FINISHED;
                done   <= 1'b1;
              end else begin
                cursor <= cursor + IDX_W'(1);
                state  <= ST_WAIT;
              end
            end else begin
              if (err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + ERR_W'(1);
              end
              state <= ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          if (key_acc) begin
            state <= ST_IDLE;
            phase <= PHASE_TITLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          phase <= PHASE_TITLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_typing_session_ctrl.sv
// Bench for typing_session_ctrl: behavioural ROM, a hold-until-ack renderer and a keystroke stream,
// with key results and VGA reads checked by queue-based monitors against a session model.
module tb_typing_session_ctrl;

  localparam int MAIN_LEN   = 192;
  localparam int IDX_W      = 12;
  localparam int ERR_W      = 8;
  localparam int STARVE_MAX = 8;
`ifdef TYPING_BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_valid = 1'b0;
  logic [6:0]       key_code = '0;
  logic             key_ready;
  logic             vga_req = 1'b0;
  logic [1:0]       vga_sel = '0;
  logic [IDX_W-1:0] vga_idx = '0;
  logic             vga_ack;
  logic [6:0]       vga_char;
  logic [1:0]       rom_sel;
  logic [IDX_W-1:0] rom_idx;
  logic [6:0]       rom_char;
  logic [1:0]       phase;
  logic [IDX_W-1:0] cursor;
  logic [ERR_W-1:0] err_cnt;
  logic             done;

  typedef struct {
    int phase;
    int cursor;
    int err;
  } exp_t;

  exp_t       key_exp[$];
  logic [6:0] vga_q[$];
  int         total = 0;
  int         bad = 0;
  int         vga_mode = 0;
  int         m_phase = 0;
  int         m_cursor = 0;
  int         m_err = 0;

  always #5 clk = ~clk;

  typing_session_ctrl #(
    .MAIN_LEN(MAIN_LEN), .IDX_W(IDX_W), .ERR_W(ERR_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .vga_req(vga_req), .vga_sel(vga_sel), .vga_idx(vga_idx), .vga_ack(vga_ack), .vga_char(vga_char),
    .rom_sel(rom_sel), .rom_idx(rom_idx), .rom_char(rom_char),
    .phase(phase), .cursor(cursor), .err_cnt(err_cnt), .done(done)
  );

  function automatic logic [6:0] rom_fn(input logic [1:0] sel, input logic [IDX_W-1:0] idx);
    if (sel == 2'd1) return 7'(32'h41 + (int'(idx) * 15) % 26);
    return 7'(32'h20 + (int'(sel) * 37 + int'(idx) * 11) % 95);
  endfunction

  assign rom_char = rom_fn(rom_sel, rom_idx);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Session rules applied to one accepted keystroke.
  task automatic model_key(input logic [6:0] code);
    exp_t e;
    if (m_phase == 0) begin
      m_phase = 1; m_cursor = 0; m_err = 0;
    end else if (m_phase == 1) begin
      if (BS_EN && code == 7'h08) begin
        if (m_cursor > 0) m_cursor--;
      end else if (code == rom_fn(2'd1, IDX_W'(m_cursor))) begin
        m_cursor++;
        if (m_cursor == MAIN_LEN) m_phase = 3;
      end else if (m_err < 255) begin
        m_err++;
      end
    end else begin
      m_phase = 0;
    end
    e.phase = m_phase; e.cursor = m_cursor; e.err = m_err;
    key_exp.push_back(e);
  endtask

  task automatic send_key(input logic [6:0] code);
    int w;
    w = 0;
    @(negedge clk); #1;
    while (!key_ready && w < 40) begin
      @(negedge clk); #1;
      w++;
    end
    if (!key_ready) begin
      fail_now("key_ready_wait");
      return;
    end
    model_key(code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    do begin
      @(negedge clk); #3;
      w++;
    end while (!key_ready && w < 30);
    if (!key_ready) fail_now("wait_idle");
  endtask

  function automatic logic [6:0] right_key();
    return rom_fn(2'd1, IDX_W'(m_cursor));
  endfunction

  // Key result monitor
  initial begin
    bit   pend;
    int   lat;
    exp_t e;
    pend = 0;
    lat  = 0;
    forever begin
      @(negedge clk); #2;
      if (pend) begin
        lat++;
        if (!rst_n) begin
          if (key_exp.size() > 0) void'(key_exp.pop_front());
          pend = 0;
        end else if (key_ready) begin
          if (key_exp.size() == 0) begin
            fail_now("key_spurious");
          end else begin
            e = key_exp.pop_front();
            check("key_phase", phase, e.phase);
            check("key_cursor", cursor, e.cursor);
            check("key_err", err_cnt, e.err);
            check("key_done", done, e.phase == 3);
            check("key_latency_ok", lat <= STARVE_MAX + 2, 1);
          end
          pend = 0;
        end else if (lat > STARVE_MAX + 4) begin
          fail_now("key_result_timeout");
          if (key_exp.size() > 0) void'(key_exp.pop_front());
          pend = 0;
        end
      end
      if (!pend && rst_n && key_valid && key_ready) begin
        pend = 1;
        lat  = 0;
      end
    end
  end

  // VGA read monitor
  initial begin
    logic [6:0] e;
    forever begin
      @(negedge clk);
      if (vga_ack) begin
        if (vga_q.size() == 0) begin
          fail_now("vga_spurious_ack");
        end else begin
          e = vga_q.pop_front();
          check("vga_char", vga_char, e);
        end
      end
    end
  end

  // Renderer: holds each request until acked, then may issue the next one in the same cycle.
  initial begin
    int held;
    held = 0;
    forever begin
      @(negedge clk); #1;
      if (vga_req) begin
        if (vga_ack) begin
          vga_req = 1'b0;
          held = 0;
        end else begin
          held++;
          if (held > 40) begin
            fail_now("vga_req_starved");
            vga_q.delete();
            vga_req = 1'b0;
            held = 0;
          end
        end
      end
      if (!vga_req && (vga_mode == 2 || (vga_mode == 1 && $urandom_range(0, 1) == 1))) begin
        if (vga_mode == 2) begin
          vga_sel = 2'd0;
          vga_idx = IDX_W'(5);
        end else begin
          vga_sel = 2'($urandom_range(0, 3));
          vga_idx = IDX_W'($urandom_range(0, 4095));
        end
        vga_q.push_back(rom_fn(vga_sel, vga_idx));
        vga_req = 1'b1;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       ack_seen[1:10];
    int         first_ready;
    logic [6:0] k;

    // Reset behaviour, including a key offered while in reset
    key_valid = 1'b1;
    key_code  = 7'h58;
    repeat (2) @(negedge clk);
    #3;
    check("rst_phase", phase, 0);
    check("rst_cursor", cursor, 0);
    check("rst_err", err_cnt, 0);
    check("rst_done", done, 0);
    check("rst_vga_ack", vga_ack, 0);
    check("rst_vga_char", vga_char, 0);
    check("rst_rom_sel", rom_sel, 0);
    check("rst_rom_idx", rom_idx, 0);
    check("rst_key_ready", key_ready, 1);
    key_valid = 1'b0;
    @(negedge clk); #4;
    rst_n = 1'b1;
    @(negedge clk); #3;
    check("no_key_in_reset", phase, 0);

    // Start session, one correct key, one wrong key, no VGA traffic
    send_key(7'h58);
    wait_idle();
    send_key(7'h41);
    check("cmp_rom_sel", rom_sel, 1);
    check("cmp_rom_idx", rom_idx, 0);
    check("cmp_key_ready", key_ready, 0);
    wait_idle();
    check("after_a_cursor", cursor, 1);
    send_key(7'h51);
    wait_idle();
    check("after_q_err", err_cnt, 1);
    check("after_q_cursor", cursor, 1);

    // Compare starved by a saturating renderer
    vga_mode = 2;
    repeat (4) @(negedge clk);
    send_key(right_key());
    first_ready = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #3;
      ack_seen[i] = vga_ack;
      if (first_ready == 0 && key_ready) first_ready = i;
    end
    for (int i = 1; i <= 10; i++) begin
      check($sformatf("starve_ack_%0d", i), ack_seen[i], (i == 9) ? 0 : 1);
    end
    check("starve_latency", first_ready, 9);

    // Random typing with random renderer traffic until the prompt is complete
    vga_mode = 1;
    for (int n = 0; n < 3000 && m_phase != 3; n++) begin
      case ($urandom_range(0, 15))
        0:       k = 7'h08;
        1, 2, 3: k = 7'($urandom_range(65, 90));
        default: k = right_key();
      endcase
      send_key(k);
    end
    wait_idle();
    check("final_done", done, 1);
    check("final_cursor", cursor, MAIN_LEN);
    check("final_phase", phase, 3);
    send_key(7'($urandom_range(65, 90)));
    wait_idle();
    check("title_phase", phase, 0);
    check("title_cursor_hold", cursor, MAIN_LEN);
    check("title_done", done, 0);

    // Backspace handling
    send_key(7'h4E);
    for (int i = 0; i < 3; i++) send_key(right_key());
    wait_idle();
    check("bs_pre_cursor", cursor, 3);
    send_key(7'h08);
    check("bs_no_compare", key_ready, BS_EN ? 1 : 0);
    wait_idle();
    check("bs_cursor", cursor, BS_EN ? 2 : 3);
    check("bs_err", err_cnt, BS_EN ? 0 : 1);
    for (int i = 0; i < 3; i++) send_key(7'h08);
    wait_idle();
    check("bs_floor_cursor", cursor, BS_EN ? 0 : 3);
    check("bs_floor_err", err_cnt, BS_EN ? 0 : 4);

    // Error counter saturation
    for (int i = 0; i < 300; i++) send_key(right_key() ^ 7'h01);
    wait_idle();
    check("sat_err", err_cnt, 255);
    check("sat_cursor", cursor, BS_EN ? 0 : 3);

    // Reset asserted while a compare is starved
    vga_mode = 2;
    repeat (3) @(negedge clk);
    send_key(right_key());
    @(negedge clk);
    @(negedge clk); #4;
    rst_n = 1'b0;
    #1;
    check("midrst_phase", phase, 0);
    check("midrst_cursor", cursor, 0);
    check("midrst_err", err_cnt, 0);
    check("midrst_key_ready", key_ready, 1);
    check("midrst_rom_sel", rom_sel, 0);
    check("midrst_rom_idx", rom_idx, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      check("midrst_no_ack", vga_ack, 0);
    end
    @(negedge clk); #4;
    rst_n = 1'b1;
    m_phase = 0; m_cursor = 0; m_err = 0;
    repeat (20) @(negedge clk);

    // Drain the renderer and start one more session
    vga_mode = 0;
    for (int w = 0; w < 100 && (vga_req || vga_q.size() != 0); w++) @(negedge clk);
    #3;
    check("vga_drained", vga_q.size(), 0);
    send_key(7'h41);
    wait_idle();
    check("restart_phase", phase, 1);
    repeat (2) @(negedge clk);
    check("key_queue_empty", key_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/typing_session_ctrl.md
# typing_session_ctrl

Sequences one typing session and owns the single combinational read port of the prompt ROM (2-bit selection, 12-bit index, 7-bit ASCII out). The block runs the title → typing → finished state machine, checks each accepted keystroke against the main prompt at the cursor, and counts errors. It shares the ROM port between the VGA text renderer and the internal compare engine. It sits between the keyboard decoder, the VGA character fetcher and the ROM.

## Interface
- `MAIN_LEN`, default 192: main prompt length in characters.
- `IDX_W`, default 12: ROM index and cursor width.
- `ERR_W`, default 8: error counter width.
- `STARVE_MAX`, default 8: maximum number of cycles a pending compare may lose arbitration to VGA.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `key_valid`, in, 1: keystroke offered.
- `key_code`, in, 7: uppercase ASCII of the keystroke.
- `key_ready`, out, 1: controller can accept a key.
- `vga_req`, in, 1: renderer read request.
- `vga_sel`, in, 2: renderer ROM selection.
- `vga_idx`, in, IDX_W: renderer ROM index.
- `vga_ack`, out, 1: `vga_char` valid for the request granted last cycle.
- `vga_char`, out, 7: registered ROM data for the renderer.
- `rom_sel`, out, 2: to ROM selection.
- `rom_idx`, out, IDX_W: to ROM index.
- `rom_char`, in, 7: ROM data, combinational, same cycle.
- `phase`, out, 2: 0 = title, 1 = typing, 3 = finished.
- `cursor`, out, IDX_W: next main-prompt index to type.
- `err_cnt`, out, ERR_W: mismatched keystrokes.
- `done`, out, 1: session complete.

## Operation
- States: IDLE, WAIT, CMP, DONE.
- A key is accepted on a rising edge where `key_valid && key_ready`. `key_ready` = (state != CMP).
- IDLE: any accepted key → WAIT. `cursor` ← 0, `err_cnt` ← 0.
- WAIT: accepted key → `key_q` ← `key_code`, state → CMP.
- CMP: compare engine requests ROM with sel = 1, idx = `cursor`. On the granted cycle, compare `rom_char` with `key_q`:
  - Match and `cursor` = MAIN_LEN−1: `cursor` ← MAIN_LEN, state → DONE.
  - Other match: `cursor` +1, state → WAIT.
  - Mismatch: `err_cnt` +1, saturating at 2^ERR_W−1. `cursor` unchanged. State → WAIT.
- DONE: any accepted key → IDLE. `cursor` and `err_cnt` hold their values until the next IDLE exit.
- Arbitration:
  - VGA wins by default.
  - The compare engine wins when `vga_req` = 0, or when `starve_cnt` = STARVE_MAX.
  - `starve_cnt` increments each CMP cycle that compare loses, and clears on leaving CMP.
  - A denied VGA request gets no ack. The renderer holds `req`/`sel`/`idx` until acked.
- `rom_sel`/`rom_idx` are combinational:
  - VGA granted: `vga_sel`/`vga_idx`.
  - Compare granted: 1/`cursor`.
  - Otherwise: `vga_sel`/`vga_idx`.
  - Forced to 0/0 while `rst_n` = 0.
- `phase` decodes the state: IDLE → 0, WAIT/CMP → 1, DONE → 3. `done` = (state == DONE).
- Reset mid-operation: any state → IDLE immediately. A pending key is dropped and a pending VGA request is unacked.

## Timing
- Reset values: state IDLE, `cursor` 0, `err_cnt` 0, `vga_ack` 0, `vga_char` 0, `key_q` 0, `starve_cnt` 0, `phase` 0, `done` 0, `rom_sel`/`rom_idx` 0.
- `key_ready` reads 1 during reset, but no key is accepted while `rst_n` = 0.
- VGA read: request granted in cycle N. `vga_ack` = 1 and `vga_char` = `rom_char`(N) in cycle N+1. One read per cycle is supported back-to-back.
- Key to result: key accepted at edge E. Compare occurs in the first granted cycle after E. `cursor`/`err_cnt` update at the following edge, at minimum E+1, at maximum E+1+STARVE_MAX.
- `key_ready` falls the cycle after acceptance and rises the cycle after compare.
- A simultaneous `vga_req` and compare grant resolves as specified above. Neither request is ever lost.

## Configuration
- `TYPING_BACKSPACE_EN` defined: in WAIT, `key_code` 0x08 decrements `cursor` (floor 0) in one cycle. There is no ROM access, `err_cnt` is unchanged, and state stays WAIT.
- Undefined: 0x08 is an ordinary key, is compared, and always mismatches.

## Structure
- Package `typing_pkg`:
  - Selection constants SEL_TITLE = 0, SEL_MAIN = 1, SEL_INIT = 2, SEL_FINAL = 3.
  - Phase encoding.
  - ASCII_BS = 7'h08.
  - State enum.
- Sub-module `rom_port_arb`: owns the grant logic, `starve_cnt`, the `rom_sel`/`rom_idx` mux and the `vga_ack`/`vga_char` registers.

## Test plan
- Reset, then key 0x58 in IDLE → next cycle `phase` = 1, `cursor` = 0, `err_cnt` = 0.
- No VGA traffic; type 0x41 → in CMP `rom_sel` = 1, `rom_idx` = 0, then `cursor` = 1. Type 0x51 (expected 0x50) → `err_cnt` = 1, `cursor` = 1.
- `vga_req` held high (sel 0, idx 5) with a key pending → `vga_ack` for 8 consecutive cycles, then a one-cycle gap in which the compare completes, then VGA resumes with no lost request.
- Type all 192 correct characters → `done` = 1, `cursor` = 192, `phase` = 3. Next key → `phase` = 0.
- 300 wrong keys → `err_cnt` saturates at 255. Assert `rst_n` low during CMP → IDLE, `cursor` = 0, no ack.
- With `TYPING_BACKSPACE_EN`: 0x08 at `cursor` 3 → 2, and at 0 → 0, with no ROM compare. Without the macro: 0x08 → `err_cnt` +1.
